// File: rtl/decode_stage.sv
// Decode stage: an instruction queue feeding an RV32I(+M) decoder with a registered,
// valid/ready output. Flush and reset discard everything that is in flight.
module decode_stage #(
    parameter int unsigned IQ_DEPTH = 4,
    parameter bit          ENABLE_M = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_instr,
    input  logic [31:0]               in_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_pc,
    output logic [4:0]                out_alu_control,
    output logic [2:0]                out_imm_type,
    output logic                      out_reg_write,
    output logic                      out_mem_read,
    output logic                      out_mem_write,
    output logic                      out_alu_src,
    output logic                      out_branch,
    output logic                      out_jump,
    output logic [1:0]                out_wb_src,
    output logic [2:0]                out_funct3,
    output logic [4:0]                out_rd,
    output logic [4:0]                out_rs1,
    output logic [4:0]                out_rs2,
    output logic                      out_illegal,
    output logic [$clog2(IQ_DEPTH):0] iq_count
);

    localparam int unsigned PW = $clog2(IQ_DEPTH);
    localparam logic [PW:0] DepthC = (PW + 1)'(IQ_DEPTH);

    localparam logic [4:0] AluAdd  = 5'd0;
    localparam logic [4:0] AluSub  = 5'd1;
    localparam logic [4:0] AluAnd  = 5'd2;
    localparam logic [4:0] AluOr   = 5'd3;
    localparam logic [4:0] AluXor  = 5'd4;
    localparam logic [4:0] AluSlt  = 5'd5;
    localparam logic [4:0] AluSltu = 5'd6;
    localparam logic [4:0] AluSll  = 5'd7;
    localparam logic [4:0] AluSrl  = 5'd8;
    localparam logic [4:0] AluSra  = 5'd9;
    localparam logic [4:0] AluMul  = 5'd10;

    localparam logic [2:0] ImmI = 3'd0;
    localparam logic [2:0] ImmS = 3'd1;
    localparam logic [2:0] ImmB = 3'd2;
    localparam logic [2:0] ImmU = 3'd3;
    localparam logic [2:0] ImmJ = 3'd4;

    localparam logic [6:0] F7Zero = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;
    localparam logic [6:0] F7Mul  = 7'b0000001;

    logic [63:0]   iq_mem [IQ_DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [PW:0]   count_q;
    logic          push, load;
    logic [31:0]   head_instr, head_pc;
    logic [6:0]    opcode, funct7;
    logic [2:0]    funct3;
    logic [4:0]    alu_base;

    logic [4:0] dec_alu;
    logic [2:0] dec_imm;
    logic [1:0] dec_wb;
    logic       dec_reg_write, dec_mem_read, dec_mem_write, dec_alu_src;
    logic       dec_branch, dec_jump, dec_illegal;

    assign in_ready   = count_q < DepthC;
    assign iq_count   = count_q;
    // Flush wins over both the push and the output-register load in the same cycle.
    assign push       = in_valid && in_ready && !flush;
    assign load       = (count_q != '0) && (!out_valid || out_ready) && !flush;
    assign head_instr = iq_mem[rd_ptr_q][63:32];
    assign head_pc    = iq_mem[rd_ptr_q][31:0];
    assign opcode     = head_instr[6:0];
    assign funct3     = head_instr[14:12];
    assign funct7     = head_instr[31:25];

    // Queue storage: written on push, never reset.
    always_ff @(posedge clk) begin
        if (push) iq_mem[wr_ptr_q] <= {in_instr, in_pc};
    end

    // Queue pointers and occupancy; pointers wrap naturally as IQ_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (load) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !load)      count_q <= count_q + 1'b1;
            else if (!push && load) count_q <= count_q - 1'b1;
        end
    end

    // ALU op selected by funct3 alone (ADD / SRL variants).
    always_comb begin
        alu_base = AluAdd;
        unique case (funct3)
            3'b000: alu_base = AluAdd;
            3'b001: alu_base = AluSll;
            3'b010: alu_base = AluSlt;
            3'b011: alu_base = AluSltu;
            3'b100: alu_base = AluXor;
            3'b101: alu_base = AluSrl;
            3'b110: alu_base = AluOr;
            default: alu_base = AluAnd;
        endcase
    end

    // Decode the queue head into control signals.
    always_comb begin
        dec_alu       = AluAdd;
        dec_imm       = ImmI;
        dec_wb        = 2'd0;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_alu_src   = 1'b0;
        dec_branch    = 1'b0;
        dec_jump      = 1'b0;
        dec_illegal   = 1'b0;
        unique case (opcode)
            7'b0110011: begin
                dec_reg_write = 1'b1;
                if (funct7 == F7Zero) begin
                    dec_alu = alu_base;
                end else if (funct7 == F7Alt && funct3 == 3'b000) begin
                    dec_alu = AluSub;
                end else if (funct7 == F7Alt && funct3 == 3'b101) begin
                    dec_alu = AluSra;
                end else if (ENABLE_M && funct7 == F7Mul) begin
                    dec_alu = AluMul + {2'b00, funct3};
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            7'b0010011: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu       = alu_base;
                if (funct3 == 3'b001 && funct7 != F7Zero) dec_illegal = 1'b1;
                if (funct3 == 3'b101) begin
                    if (funct7 == F7Alt)       dec_alu     = AluSra;
                    else if (funct7 != F7Zero) dec_illegal = 1'b1;
                end
            end
            7'b0000011: begin
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
                dec_alu_src   = 1'b1;
                dec_wb        = 2'd1;
                dec_illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            7'b0100011: begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_imm       = ImmS;
                dec_illegal   = funct3 > 3'b010;
            end
            7'b1100011: begin
                dec_branch  = 1'b1;
                dec_imm     = ImmB;
                dec_alu     = AluSub;
                dec_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            7'b1101111: begin
                dec_reg_write = 1'b1;
                dec_jump      = 1'b1;
                dec_wb        = 2'd2;
                dec_imm       = ImmJ;
            end
            7'b1100111: begin
                dec_reg_write = 1'b1;
                dec_jump      = 1'b1;
                dec_alu_src   = 1'b1;
                dec_wb        = 2'd2;
                dec_illegal   = funct3 != 3'b000;
            end
            7'b0110111, 7'b0010111: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_imm       = ImmU;
            end
            default: dec_illegal = 1'b1;
        endcase
        // Illegal instructions still flow through, but with every side effect suppressed.
        if (dec_illegal) begin
            dec_alu       = AluAdd;
            dec_imm       = ImmI;
            dec_wb        = 2'd0;
            dec_reg_write = 1'b0;
            dec_mem_read  = 1'b0;
            dec_mem_write = 1'b0;
            dec_alu_src   = 1'b0;
            dec_branch    = 1'b0;
            dec_jump      = 1'b0;
        end
        if (head_instr[11:7] == 5'd0) dec_reg_write = 1'b0;
    end

    // Output register: loads the decoded head, holds under backpressure, drains when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid       <= 1'b0;
            out_pc          <= '0;
            out_alu_control <= '0;
            out_imm_type    <= '0;
            out_reg_write   <= 1'b0;
            out_mem_read    <= 1'b0;
            out_mem_write   <= 1'b0;
            out_alu_src     <= 1'b0;
            out_branch      <= 1'b0;
            out_jump        <= 1'b0;
            out_wb_src      <= '0;
            out_funct3      <= '0;
            out_rd          <= '0;
            out_rs1         <= '0;
            out_rs2         <= '0;
            out_illegal     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid       <= 1'b1;
            out_pc          <= head_pc;
            out_alu_control <= dec_alu;
            out_imm_type    <= dec_imm;
            out_reg_write   <= dec_reg_write;
            out_mem_read    <= dec_mem_read;
            out_mem_write   <= dec_mem_write;
            out_alu_src     <= dec_alu_src;
            out_branch      <= dec_branch;
            out_jump        <= dec_jump;
            out_wb_src      <= dec_wb;
            out_funct3      <= funct3;
            out_rd          <= head_instr[11:7];
            out_rs1         <= head_instr[19:15];
            out_rs2         <= head_instr[24:20];
            out_illegal     <= dec_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (M extension off / on) share the same stimulus.
module tb_decode_stage;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic       ill;
        logic [5:0] flags;   // {reg_write, mem_read, mem_write, alu_src, branch, jump}
        logic [1:0] wb;
        logic [4:0] alu;
        logic [2:0] imm;
        logic       care_alu;
        logic       care_imm;
    } dec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } item_t;

    // alu=31 / imm=7 mean "not defined for this instruction, don't compare"
    typedef struct {
        logic [31:0] instr;
        logic        ill0;
        logic        ill1;
        logic [5:0]  flags;
        logic [1:0]  wb;
        logic [4:0]  alu;
        logic [2:0]  imm;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic [1:0]  in_ready, out_valid, out_reg_write, out_mem_read, out_mem_write;
    logic [1:0]  out_alu_src, out_branch, out_jump, out_illegal;
    logic [31:0] out_pc [2];
    logic [4:0]  out_alu_control [2];
    logic [2:0]  out_imm_type [2];
    logic [1:0]  out_wb_src [2];
    logic [2:0]  out_funct3 [2];
    logic [4:0]  out_rd [2];
    logic [4:0]  out_rs1 [2];
    logic [4:0]  out_rs2 [2];
    logic [2:0]  iq_count [2];

    int total = 0;
    int bad = 0;
    item_t sb [2][$];
    logic [1:0]  hold_prev;
    logic [95:0] prev [2];
    int delivered [2];
    logic last_push;
    vec_t vt [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        decode_stage #(.IQ_DEPTH(DEPTH), .ENABLE_M(g == 1)) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .flush           (flush),
            .in_valid        (in_valid),
            .in_ready        (in_ready[g]),
            .in_instr        (in_instr),
            .in_pc           (in_pc),
            .out_valid       (out_valid[g]),
            .out_ready       (out_ready),
            .out_pc          (out_pc[g]),
            .out_alu_control (out_alu_control[g]),
            .out_imm_type    (out_imm_type[g]),
            .out_reg_write   (out_reg_write[g]),
            .out_mem_read    (out_mem_read[g]),
            .out_mem_write   (out_mem_write[g]),
            .out_alu_src     (out_alu_src[g]),
            .out_branch      (out_branch[g]),
            .out_jump        (out_jump[g]),
            .out_wb_src      (out_wb_src[g]),
            .out_funct3      (out_funct3[g]),
            .out_rd          (out_rd[g]),
            .out_rs1         (out_rs1[g]),
            .out_rs2         (out_rs2[g]),
            .out_illegal     (out_illegal[g]),
            .iq_count        (iq_count[g])
        );
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decode straight from the ISA rules.
    function automatic dec_t decode_ref(input logic [31:0] ins, input bit en_m);
        dec_t d;
        int f3;
        logic [6:0] f7;
        int base_alu [8] = '{0, 7, 5, 6, 4, 8, 3, 2};
        d = '0;
        d.care_alu = 1'b1;
        d.care_imm = 1'b1;
        f3 = int'(ins[14:12]);
        f7 = ins[31:25];
        case (ins[6:0])
            7'h33: begin
                d.flags = 6'b100000;
                d.care_imm = 1'b0;
                if (f7 == 7'h00) d.alu = 5'(base_alu[f3]);
                else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) d.alu = 5'(base_alu[f3] + 1);
                else if (f7 == 7'h01 && en_m) d.alu = 5'(10 + f3);
                else d.ill = 1'b1;
            end
            7'h13: begin
                d.flags = 6'b100100;
                d.alu = 5'(base_alu[f3]);
                if (f3 == 1 && f7 != 7'h00) d.ill = 1'b1;
                if (f3 == 5) begin
                    if (f7 == 7'h20) d.alu = 5'd9;
                    else if (f7 != 7'h00) d.ill = 1'b1;
                end
            end
            7'h03: begin
                d.flags = 6'b110100;
                d.wb = 2'd1;
                d.ill = (f3 == 3 || f3 == 6 || f3 == 7);
            end
            7'h23: begin
                d.flags = 6'b001100;
                d.imm = 3'd1;
                d.ill = f3 > 2;
            end
            7'h63: begin
                d.flags = 6'b000010;
                d.imm = 3'd2;
                d.alu = 5'd1;
                d.ill = (f3 == 2 || f3 == 3);
            end
            7'h6F: begin
                d.flags = 6'b100001;
                d.wb = 2'd2;
                d.imm = 3'd4;
                d.care_alu = 1'b0;
            end
            7'h67: begin
                d.flags = 6'b100101;
                d.wb = 2'd2;
                d.care_alu = 1'b0;
                d.ill = f3 != 0;
            end
            7'h37, 7'h17: begin
                d.flags = 6'b100100;
                d.imm = 3'd3;
            end
            default: d.ill = 1'b1;
        endcase
        if (ins[11:7] == 5'd0) d.flags[5] = 1'b0;
        if (d.ill) begin
            d.flags = '0;
            d.alu = '0;
            d.wb = '0;
            d.care_alu = 1'b1;
            d.care_imm = 1'b0;
        end
        return d;
    endfunction

    function automatic logic [95:0] obs(input int k, input logic [5:0] fm, input logic wm,
                                        input logic am, input logic im);
        logic [5:0] f;
        f = {out_reg_write[k], out_mem_read[k], out_mem_write[k], out_alu_src[k],
             out_branch[k], out_jump[k]};
        return {29'b0, out_illegal[k], f & fm, out_wb_src[k] & {2{wm}},
                out_alu_control[k] & {5{am}}, out_imm_type[k] & {3{im}}, out_pc[k],
                out_funct3[k], out_rd[k], out_rs1[k], out_rs2[k]};
    endfunction

    function automatic logic [95:0] snap(input int k);
        return obs(k, 6'h3f, 1'b1, 1'b1, 1'b1) | (96'(out_valid[k]) << 80);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
        logic [31:0] r;
        r = $urandom;
        r[6:0] = ops[$urandom_range(0, 9)];
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            2: r[31:25] = 7'h01;
            default: ;
        endcase
        return r;
    endfunction

    // One clock: observe both DUTs at the falling edge, update the scoreboard, then
    // return 1 time unit after the rising edge so the caller can drive new inputs.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            int exp_cnt;
            exp_cnt = sb[k].size() - (out_valid[k] ? 1 : 0);
            chk($sformatf("count%0d", k), 96'(iq_count[k]), 96'(exp_cnt));
            chk($sformatf("in_ready%0d", k), 96'(in_ready[k]), 96'(exp_cnt < int'(DEPTH)));
            if (hold_prev[k]) chk($sformatf("hold%0d", k), snap(k), prev[k]);
            if (out_valid[k] && out_ready) begin
                if (sb[k].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious%0d: got pc %0h expected no output", k, out_pc[k]);
                end else begin
                    item_t it;
                    dec_t d;
                    logic [5:0] fm;
                    it = sb[k].pop_front();
                    d = decode_ref(it.instr, k == 1);
                    fm = d.ill ? 6'b111011 : 6'b111111;
                    chk($sformatf("deliver%0d_%08h", k, it.instr),
                        obs(k, fm, !d.ill, d.care_alu, d.care_imm),
                        {29'b0, d.ill, d.flags & fm, d.wb & {2{!d.ill}},
                         d.alu & {5{d.care_alu}}, d.imm & {3{d.care_imm}}, it.pc,
                         it.instr[14:12], it.instr[11:7], it.instr[19:15], it.instr[24:20]});
                    delivered[k]++;
                end
            end
            hold_prev[k] = out_valid[k] && !out_ready && !flush;
            prev[k] = snap(k);
            if (flush) sb[k].delete();
            else if (in_valid && in_ready[k]) sb[k].push_back('{in_instr, in_pc});
        end
        last_push = in_valid && in_ready[0] && !flush;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_out%0d", k), snap(k), 96'd0);
            chk($sformatf("rst_cnt%0d", k), 96'(iq_count[k]), 96'd0);
            chk($sformatf("rst_rdy%0d", k), 96'(in_ready[k]), 96'd1);
            sb[k].delete();
        end
        hold_prev = '0;
        in_valid = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_rdy_held", 96'(in_ready), 96'b11);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((sb[0].size() != 0 || sb[1].size() != 0) && n < 20) begin
            step();
            n++;
        end
        chk("drain_empty", 96'(sb[0].size() + sb[1].size()), 96'd0);
        step();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_instr = '0;
        in_pc = '0;
        hold_prev = '0;
        delivered[0] = 0;
        delivered[1] = 0;
        last_push = 1'b0;

        vt.push_back('{32'h002081B3, 1'b0, 1'b0, 6'b100000, 2'd0, 5'd0,  3'd7}); // ADD
        vt.push_back('{32'h402081B3, 1'b0, 1'b0, 6'b100000, 2'd0, 5'd1,  3'd7}); // SUB
        vt.push_back('{32'h022081B3, 1'b1, 1'b0, 6'b100000, 2'd0, 5'd10, 3'd7}); // MUL
        vt.push_back('{32'h0220D1B3, 1'b1, 1'b0, 6'b100000, 2'd0, 5'd15, 3'd7}); // DIVU
        vt.push_back('{32'h4020D1B3, 1'b0, 1'b0, 6'b100000, 2'd0, 5'd9,  3'd7}); // SRA
        vt.push_back('{32'h402091B3, 1'b1, 1'b1, 6'b000000, 2'd0, 5'd0,  3'd7}); // alt SLL
        vt.push_back('{32'h0000707F, 1'b1, 1'b1, 6'b000000, 2'd0, 5'd0,  3'd7}); // bad op
        vt.push_back('{32'h00100013, 1'b0, 1'b0, 6'b000100, 2'd0, 5'd0,  3'd0}); // ADDI x0
        vt.push_back('{32'h00500093, 1'b0, 1'b0, 6'b100100, 2'd0, 5'd0,  3'd0}); // ADDI x1
        vt.push_back('{32'h4030D093, 1'b0, 1'b0, 6'b100100, 2'd0, 5'd9,  3'd0}); // SRAI
        vt.push_back('{32'h40309093, 1'b1, 1'b1, 6'b000000, 2'd0, 5'd0,  3'd7}); // bad SLLI
        vt.push_back('{32'h0040A103, 1'b0, 1'b0, 6'b110100, 2'd1, 5'd0,  3'd0}); // LW
        vt.push_back('{32'h0040B103, 1'b1, 1'b1, 6'b000000, 2'd0, 5'd0,  3'd7}); // load f3=3
        vt.push_back('{32'h0020A423, 1'b0, 1'b0, 6'b001100, 2'd0, 5'd0,  3'd1}); // SW
        vt.push_back('{32'h00208463, 1'b0, 1'b0, 6'b000010, 2'd0, 5'd1,  3'd2}); // BEQ
        vt.push_back('{32'h0020A463, 1'b1, 1'b1, 6'b000000, 2'd0, 5'd0,  3'd7}); // br f3=2
        vt.push_back('{32'h010000EF, 1'b0, 1'b0, 6'b100001, 2'd2, 5'd31, 3'd4}); // JAL
        vt.push_back('{32'h000100E7, 1'b0, 1'b0, 6'b100101, 2'd2, 5'd31, 3'd0}); // JALR
        vt.push_back('{32'h000110E7, 1'b1, 1'b1, 6'b000000, 2'd0, 5'd0,  3'd7}); // JALR f3=1
        vt.push_back('{32'h123452B7, 1'b0, 1'b0, 6'b100100, 2'd0, 5'd0,  3'd3}); // LUI
        vt.push_back('{32'h00001017, 1'b0, 1'b0, 6'b000100, 2'd0, 5'd0,  3'd3}); // AUIPC x0
        vt.push_back('{32'h042081B3, 1'b1, 1'b1, 6'b000000, 2'd0, 5'd0,  3'd7}); // bad f7
        vt.push_back('{32'h0020B1B3, 1'b0, 1'b0, 6'b100000, 2'd0, 5'd6,  3'd7}); // SLTU

        do_reset();

        // Single ADD: not visible after the accepting edge, visible after the next one.
        in_valid = 1'b1;
        in_instr = 32'h002081B3;
        in_pc = 32'h100;
        step();
        in_valid = 1'b0;
        chk("add_no_bypass", 96'(out_valid), 96'b00);
        step();
        chk("add_valid", 96'(out_valid), 96'b11);
        for (int k = 0; k < 2; k++)
            chk($sformatf("add_fields%0d", k),
                {51'b0, out_alu_control[k], out_rd[k], out_rs1[k], out_rs2[k], out_reg_write[k],
                 out_pc[k]},
                {51'b0, 5'd0, 5'd3, 5'd1, 5'd2, 1'b1, 32'h100});
        drain();

        // Decode table, one instruction at a time.
        for (int i = 0; i < vt.size(); i++) begin
            int n;
            in_valid = 1'b1;
            in_instr = vt[i].instr;
            in_pc = 32'h1000 + 32'(i * 4);
            out_ready = 1'b0;
            step();
            in_valid = 1'b0;
            n = 0;
            while (out_valid != 2'b11 && n < 5) begin
                step();
                n++;
            end
            chk($sformatf("tbl_wait%0d", i), 96'(out_valid), 96'b11);
            for (int k = 0; k < 2; k++) begin
                logic ill;
                logic [4:0] am;
                logic [2:0] im;
                ill = (k == 1) ? vt[i].ill1 : vt[i].ill0;
                am = (vt[i].alu == 5'd31) ? 5'd0 : 5'h1f;
                im = (vt[i].imm == 3'd7) ? 3'd0 : 3'h7;
                if (ill)
                    chk($sformatf("tbl%0d_ill%0d", i, k),
                        {84'b0, out_illegal[k], out_reg_write[k], out_mem_read[k],
                         out_mem_write[k], out_branch[k], out_jump[k], out_alu_control[k],
                         1'b0},
                        {84'b0, 1'b1, 5'b0, 5'd0, 1'b0});
                else
                    chk($sformatf("tbl%0d_dec%0d", i, k),
                        {79'b0, out_illegal[k], out_reg_write[k], out_mem_read[k],
                         out_mem_write[k], out_alu_src[k], out_branch[k], out_jump[k],
                         out_wb_src[k], out_alu_control[k] & am, out_imm_type[k] & im},
                        {79'b0, 1'b0, vt[i].flags, vt[i].wb, vt[i].alu & am, vt[i].imm & im});
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        drain();

        // Backpressure fill: 5 accepted, 4 queued + 1 held, then in-order release.
        delivered[0] = 0;
        delivered[1] = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fill_rdy%0d", i), 96'(in_ready), 96'b11);
            in_valid = 1'b1;
            in_instr = rand_instr();
            in_pc = 32'h200 + 32'(i * 4);
            step();
        end
        in_valid = 1'b0;
        chk("fill_full", {93'b0, in_ready, out_valid[0]}, {93'b0, 2'b00, 1'b1});
        chk("fill_count", {90'b0, iq_count[0], iq_count[1]}, {90'b0, 3'd4, 3'd4});
        drain();
        chk("fill_delivered", {64'b0, 32'(delivered[0]), 32'(delivered[1])},
            {64'b0, 32'd5, 32'd5});

        // Flush with 3 queued and a simultaneous push attempt.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_instr = rand_instr();
            in_pc = 32'h300 + 32'(i * 4);
            step();
        end
        chk("pre_flush_count", 96'(iq_count[1]), 96'd3);
        flush = 1'b1;
        in_instr = 32'h00500093;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_state", {90'b0, iq_count[0], iq_count[1]} | (96'(out_valid) << 6),
            96'd0);
        out_ready = 1'b1;
        step();
        step();

        // Asynchronous reset pulse mid-stream, then no output until a new push.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_instr = rand_instr();
            in_pc = 32'h400 + 32'(i * 4);
            step();
        end
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("post_rst_quiet", 96'(out_valid), 96'b00);

        // 20 back-to-back pushes under random backpressure: wraps the pointers.
        begin
            int acc, guard;
            acc = 0;
            guard = 0;
            in_valid = 1'b1;
            in_instr = rand_instr();
            in_pc = 32'h800;
            while (acc < 20 && guard < 400) begin
                out_ready = 1'($urandom);
                step();
                if (last_push) begin
                    acc++;
                    in_instr = rand_instr();
                    in_pc = 32'h800 + 32'(acc * 4);
                end
                guard++;
            end
            chk("wrap_accepted", 96'(acc), 96'd20);
        end
        drain();

        // Free-running random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom);
            in_instr = rand_instr();
            in_pc = 32'($urandom) & ~32'h3;
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 29) == 0);
            step();
        end
        flush = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter IQ_DEPTH, default 4, instruction-queue entries; power of two, at least 2.
REQ-002 Parameter ENABLE_M, default 0, 1 = decode the RV32M extension, 0 = M encodings are illegal.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 flush  in  1  synchronous pipeline flush.
REQ-007 in_valid / in_ready  in / out  1 / 1  fetch-side handshake.
REQ-008 in_instr / in_pc  in  32 / 32  fetched instruction and its PC.
REQ-009 out_valid / out_ready  out / in  1 / 1  issue-side handshake.
REQ-010 out_pc  out  32  PC of the decoded instruction.
REQ-011 out_alu_control  out  5  ALU op:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA;
- 10-17 MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-012 out_imm_type  out  3  immediate type: I=0, S=1, B=2, U=3, J=4.
REQ-013 out_reg_write, out_mem_read, out_mem_write, out_alu_src, out_branch, out_jump  out  1 each  control flags.
REQ-014 out_wb_src  out  2  write-back source: 0 ALU, 1 memory, 2 PC+4.
REQ-015 out_funct3, out_rd, out_rs1, out_rs2  out  3, 5, 5, 5  raw instruction fields.
REQ-016 out_illegal  out  1  decoded instruction is illegal.
REQ-017 iq_count  out  $clog2(IQ_DEPTH)+1  current queue occupancy.

Function
REQ-018 Queue: circular FIFO of {instr, pc}; push on in_valid&&in_ready, pop when the output register loads.
REQ-019 in_ready SHALL be 1 iff iq_count<IQ_DEPTH; it is combinational and independent of out_ready.
REQ-020 Output register SHALL load the decoded queue head when the queue is non-empty && (!out_valid || out_ready).
REQ-021 Queue empty and out_valid&&out_ready: out_valid SHALL go to 0 on the next edge.
REQ-022 Latency: an instruction accepted at edge N SHALL appear with out_valid=1 after edge N+1 (no bypass).
REQ-023 Throughput: one instruction per cycle sustained; simultaneous push and pop SHALL keep iq_count unchanged.
REQ-024 Pointer arithmetic: read and write pointers SHALL wrap modulo IQ_DEPTH.
REQ-025 Output stability: while out_valid && !out_ready, all out_* SHALL hold stable.
REQ-026 Base decode, opcode to controls:
- R: reg_write, ALU from funct3 and funct7[5].
- I-ALU: reg_write, alu_src, IMM_I.
- LOAD: reg_write, mem_read, alu_src, wb=1, ADD.
- STORE: mem_write, alu_src, IMM_S, ADD.
- BRANCH: branch, IMM_B, SUB.
- JAL: reg_write, jump, wb=2, IMM_J.
- JALR: reg_write, jump, alu_src, wb=2, IMM_I.
- LUI/AUIPC: reg_write, alu_src, IMM_U, ADD.
REQ-027 ENABLE_M=1: R-type with funct7=0000001 SHALL map funct3 0..7 to alu_control 10..17.
REQ-028 Illegal conditions:
- unknown opcode;
- R-type funct7 not in {0000000, 0100000, 0000001 when ENABLE_M=1};
- funct7=0100000 with funct3 not in {000, 101};
- SLLI/SRLI with funct7≠0000000, SRAI with funct7≠0100000;
- LOAD funct3 in {011, 110, 111};
- STORE funct3>010;
- BRANCH funct3 in {010, 011};
- JALR funct3≠000.
REQ-029 Illegal instruction: out_illegal=1; reg_write, mem_read, mem_write, branch, jump=0; alu_control=0; the instruction is still delivered through the handshake.
REQ-030 rd=x0 SHALL force out_reg_write=0.
REQ-031 Flush: on the edge with flush=1, the queue SHALL empty (iq_count=0) and out_valid SHALL go to 0.
REQ-032 Flush dominance: in_valid in the flush cycle SHALL NOT push, even if in_ready=1.

Reset
REQ-033 rst_n=0 SHALL immediately set pointers=0, iq_count=0, out_valid=0, and all other out_* =0.
REQ-034 During and after reset in_ready SHALL be 1; queue storage contents need no reset.
REQ-035 Reset deasserted mid-stream: in-flight instructions SHALL be discarded, with no output before the next accepted push.

Verification
REQ-036 Single ADD: push 0x002081B3 at PC 0x100 into an empty stage -> out_valid after 2 edges, alu_control=0, rd=3, rs1=1, rs2=2, reg_write=1.
REQ-037 Backpressure fill (IQ_DEPTH=4, out_ready=0): push 5 instructions -> iq_count reaches 4 with one held in the output register, in_ready=0; release out_ready -> in-order delivery, no loss or duplication.
REQ-038 M decode: push 0x022081B3 (MUL) -> ENABLE_M=1: alu_control=10, illegal=0; ENABLE_M=0: illegal=1, reg_write=0.
REQ-039 Illegal and x0: push 0x0000707F (bad opcode) -> illegal=1; push ADDI x0 (0x00100013) -> reg_write=0, illegal=0.
REQ-040 Flush/reset mid-operation: flush with 3 queued and in_valid=1 -> next cycle iq_count=0, out_valid=0; async rst_n pulse mid-stream -> outputs 0 immediately.
REQ-041 Wrap-around: stream 20 back-to-back instructions with random out_ready -> pointer wrap, order preserved, count never exceeds IQ_DEPTH.
